// File: rtl/histeq_master_ctrl.sv
// Frame sequencer for the histogram-equalisation engines: runs histogram, cdf and
// divider phases in turn with turnaround gaps, a per-phase watchdog and frame counting.
module histeq_master_ctrl #(
    parameter logic [15:0] LAST_INPUT_ADDR = 16'd4095,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter logic [19:0] TIMEOUT_CYCLES  = 20'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        abort,
    input  logic [15:0] histogram_input_mem_raddr0,
    input  logic [15:0] histogram_input_mem_raddr1,
    input  logic        histogram_computation_done,
    input  logic        cdf_done,
    input  logic        output_wt_done,
    output logic        start_histogram,
    output logic        start_cdf,
    output logic        start_divider,
    output logic        input_mem_read_finished,
    output logic [1:0]  scratch_sel,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic [2:0]  phase,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIST = 3'd1,
        S_GAP1 = 3'd2,
        S_CDF  = 3'd3,
        S_GAP2 = 3'd4,
        S_DIV  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [19:0] WDOG_LAST = TIMEOUT_CYCLES - 20'd1;

    state_t      state_q;
    state_t      state_next;
    logic [19:0] wdog_q;
    logic [3:0]  gap_q;
    logic        rd_fin_q;
    logic [15:0] frame_cnt_q;
    logic        timeout;
    logic        addr_hit;

    assign timeout  = (wdog_q == WDOG_LAST);
    assign addr_hit = (histogram_input_mem_raddr0 == LAST_INPUT_ADDR) ||
                      (histogram_input_mem_raddr1 == LAST_INPUT_ADDR);

    // abort outranks everything; a done on the timeout cycle still advances the phase
    always_comb begin
        state_next = state_q;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go) state_next = S_HIST;
                S_HIST: begin
                    if (histogram_computation_done) state_next = S_GAP1;
                    else if (timeout)               state_next = S_ERR;
                end
                S_GAP1: if (gap_q == GAP_LAST) state_next = S_CDF;
                S_CDF: begin
                    if (cdf_done)     state_next = S_GAP2;
                    else if (timeout) state_next = S_ERR;
                end
                S_GAP2: if (gap_q == GAP_LAST) state_next = S_DIV;
                S_DIV: begin
                    if (output_wt_done) state_next = S_DONE;
                    else if (timeout)   state_next = S_ERR;
                end
                S_DONE:  state_next = S_IDLE;
                S_ERR:   state_next = S_ERR;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wdog_q      <= 20'd0;
            gap_q       <= 4'd0;
            rd_fin_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q <= state_next;
            // both counters restart on every state change
            if (state_next != state_q) begin
                wdog_q <= 20'd0;
                gap_q  <= 4'd0;
            end else begin
                if (state_q inside {S_HIST, S_CDF, S_DIV}) wdog_q <= wdog_q + 20'd1;
                if (state_q inside {S_GAP1, S_GAP2})       gap_q  <= gap_q + 4'd1;
            end
            rd_fin_q <= (state_q == S_HIST) && (state_next == S_HIST) && (rd_fin_q || addr_hit);
            if ((state_next == S_DONE) && (state_q != S_DONE)) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign start_histogram         = (state_q == S_HIST);
    assign start_cdf               = (state_q == S_CDF);
    assign start_divider           = (state_q == S_DIV);
    assign input_mem_read_finished = rd_fin_q;
    assign scratch_sel             = (state_q == S_HIST) ? 2'd0 :
                                     (state_q == S_CDF)  ? 2'd1 :
                                     (state_q == S_DIV)  ? 2'd2 : 2'd3;
    assign busy                    = (state_q != S_IDLE) && (state_q != S_ERR);
    assign frame_done              = (state_q == S_DONE);
    assign error                   = (state_q == S_ERR);
    assign phase                   = state_q;
    assign frame_count             = frame_cnt_q;

endmodule

// File: tb/tb_histeq_master_ctrl.sv
// Directed bench for histeq_master_ctrl: a phase/elapsed-time model checked every cycle,
// plus literal expectations for the nominal trace, read flag, timeout, abort, reset and wrap.
module tb_histeq_master_ctrl;

    localparam int          GAP  = 2;
    localparam int          TMO  = 8;
    localparam logic [15:0] LAST = 16'd4095;

    logic        clock;
    logic        reset;
    logic        go;
    logic        abort;
    logic [15:0] raddr0;
    logic [15:0] raddr1;
    logic        hdone;
    logic        cdone;
    logic        wdone;
    logic        start_histogram;
    logic        start_cdf;
    logic        start_divider;
    logic        rd_fin;
    logic [1:0]  scratch_sel;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic [2:0]  phase;
    logic [15:0] frame_count;

    histeq_master_ctrl #(
        .LAST_INPUT_ADDR(LAST),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (20'd8)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .go                        (go),
        .abort                     (abort),
        .histogram_input_mem_raddr0(raddr0),
        .histogram_input_mem_raddr1(raddr1),
        .histogram_computation_done(hdone),
        .cdf_done                  (cdone),
        .output_wt_done            (wdone),
        .start_histogram           (start_histogram),
        .start_cdf                 (start_cdf),
        .start_divider             (start_divider),
        .input_mem_read_finished   (rd_fin),
        .scratch_sel               (scratch_sel),
        .busy                      (busy),
        .frame_done                (frame_done),
        .error                     (error),
        .phase                     (phase),
        .frame_count               (frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    bit preload = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: which phase we are in and how many cycles it has lasted so far
    int m_phase = 0;
    int m_elapsed = 0;
    int m_fc = 0;
    bit m_rf = 0;
    int m_nxt;
    bit m_dn;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_elapsed = 0; m_fc = 0; m_rf = 0;
        end else begin
            if (preload) m_fc = 65535;
            m_nxt = m_phase;
            m_dn = (m_phase == 1 && hdone) || (m_phase == 3 && cdone) || (m_phase == 5 && wdone);
            if (abort) m_nxt = 0;
            else if (m_phase == 0) m_nxt = go ? 1 : 0;
            else if (m_phase == 1 || m_phase == 3 || m_phase == 5) begin
                if (m_dn) m_nxt = m_phase + 1;
                else if (m_elapsed + 1 >= TMO) m_nxt = 7;
            end else if (m_phase == 2 || m_phase == 4) begin
                if (m_elapsed + 1 >= GAP) m_nxt = m_phase + 1;
            end else if (m_phase == 6) m_nxt = 0;
            m_rf = (m_phase == 1) && (m_nxt == 1) && (m_rf || raddr0 == LAST || raddr1 == LAST);
            if (m_nxt == 6) m_fc = (m_fc + 1) % 65536;
            m_elapsed = (m_nxt == m_phase) ? m_elapsed + 1 : 0;
            m_phase = m_nxt;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("phase", phase, m_phase);
            check("start_histogram", start_histogram, m_phase == 1);
            check("start_cdf", start_cdf, m_phase == 3);
            check("start_divider", start_divider, m_phase == 5);
            check("scratch_sel", scratch_sel, (m_phase == 1) ? 0 : (m_phase == 3) ? 1 : (m_phase == 5) ? 2 : 3);
            check("busy", busy, m_phase >= 1 && m_phase <= 6);
            check("frame_done", frame_done, m_phase == 6);
            check("error", error, m_phase == 7);
            check("rd_fin", rd_fin, m_rf);
            check("frame_count", frame_count, m_fc);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From the first GAP1 cycle: finish the frame with immediate dones, end in IDLE
    task automatic finish_from_gap1();
        step(); step();
        cdone = 1'b1; step(); cdone = 1'b0;
        step(); step();
        wdone = 1'b1; step(); wdone = 1'b0;
        check("fin_done_phase", phase, 6);
        step();
    endtask

    task automatic full_frame();
        go = 1'b1; step(); go = 1'b0;
        hdone = 1'b1; step(); hdone = 1'b0;
        finish_from_gap1();
    endtask

    int exp_trace[21] = '{1,1,1,1,1,2,2,3,3,3,3,3,4,4,5,5,5,5,5,6,0};

    initial begin
        reset = 1'b1; go = 1'b0; abort = 1'b0;
        raddr0 = 16'd0; raddr1 = 16'd0;
        hdone = 1'b0; cdone = 1'b0; wdone = 1'b0;
        repeat (3) step();
        check("rst_phase", phase, 0);
        check("rst_scratch", scratch_sel, 3);
        check("rst_busy", busy, 0);
        check("rst_fc", frame_count, 0);
        check("rst_starts", {start_histogram, start_cdf, start_divider, rd_fin, error}, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        // nominal frame, each done 5 cycles after its start
        for (int i = 1; i <= 21; i++) begin
            go = (i == 1); hdone = (i == 6); cdone = (i == 13); wdone = (i == 20);
            step();
            check("nom_trace", phase, exp_trace[i-1]);
            check("nom_frame_done", frame_done, i == 20);
        end
        go = 1'b0; hdone = 1'b0; cdone = 1'b0; wdone = 1'b0;
        check("nom_fc", frame_count, 1);

        // input-read flag
        go = 1'b1; step(); go = 1'b0;
        raddr0 = 16'd4094; raddr1 = 16'd4094; step();
        check("rf_4094_a", rd_fin, 0);
        step();
        check("rf_4094_b", rd_fin, 0);
        raddr1 = 16'd4095; step();
        check("rf_set", rd_fin, 1);
        raddr1 = 16'd0; raddr0 = 16'd0; step();
        check("rf_hold", rd_fin, 1);
        hdone = 1'b1; step(); hdone = 1'b0;
        check("rf_clear", rd_fin, 0);
        check("rf_gap1", phase, 2);
        finish_from_gap1();
        check("rf_fc", frame_count, 2);

        // stray dones in HIST, then done on the timeout cycle
        go = 1'b1; step(); go = 1'b0;
        cdone = 1'b1; wdone = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stray_phase", phase, 1);
            check("stray_start_cdf", start_cdf, 0);
        end
        cdone = 1'b0; wdone = 1'b0;
        repeat (3) step();
        check("coincide_pre", phase, 1);
        hdone = 1'b1; step(); hdone = 1'b0;
        check("coincide_done_wins", phase, 2);
        finish_from_gap1();
        check("coincide_fc", frame_count, 3);

        // watchdog timeout in CDF
        go = 1'b1; step(); go = 1'b0;
        hdone = 1'b1; step(); hdone = 1'b0;
        step(); step();
        check("to_cdf_entry", phase, 3);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("to_cdf_wait", phase, 3);
        end
        step();
        check("to_err", phase, 7);
        check("to_error", error, 1);
        check("to_scratch", scratch_sel, 3);
        check("to_busy", busy, 0);
        go = 1'b1; step(); go = 1'b0;
        check("to_go_ignored", phase, 7);
        abort = 1'b1; step(); abort = 1'b0;
        check("to_abort_phase", phase, 0);
        check("to_abort_error", error, 0);
        check("to_abort_fc", frame_count, 3);

        // abort beats go in IDLE
        go = 1'b1; abort = 1'b1; step(); go = 1'b0; abort = 1'b0;
        check("abort_over_go", phase, 0);

        // reset mid-DIV
        go = 1'b1; step(); go = 1'b0;
        hdone = 1'b1; step(); hdone = 1'b0;
        step(); step();
        cdone = 1'b1; step(); cdone = 1'b0;
        step(); step();
        check("div_reached", phase, 5);
        reset = 1'b1; abort = 1'b1; step(); reset = 1'b0; abort = 1'b0;
        check("rst_div_phase", phase, 0);
        check("rst_div_start", start_divider, 0);
        check("rst_div_scratch", scratch_sel, 3);
        check("rst_div_fc", frame_count, 0);

        // abort mid-HIST keeps frame_count
        full_frame();
        go = 1'b1; step(); go = 1'b0;
        step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_hist_phase", phase, 0);
        check("abort_hist_start", start_histogram, 0);
        check("abort_hist_scratch", scratch_sel, 3);
        check("abort_hist_fc", frame_count, 1);

        // frame_count wrap
        chk_en = 1'b0;
        force dut.frame_cnt_q = 16'hFFFF;
        preload = 1'b1;
        step();
        preload = 1'b0;
        release dut.frame_cnt_q;
        chk_en = 1'b1;
        step();
        check("wrap_pre", frame_count, 16'hFFFF);
        full_frame();
        check("wrap_fc", frame_count, 0);

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/histeq_master_ctrl.md
HISTEQ_MASTER_CTRL -- requirements
Module: histeq_master_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter LAST_INPUT_ADDR, default 16'd4095: final input-memory word address of a frame.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: idle turnaround cycles between phases, legal range 1..15.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 20'd1000000: watchdog limit per phase, 20 bits, nonzero.

Ports (name, direction, width, meaning):
REQ-004 clock  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 go  in  1  frame start request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel; also clears ERR.
REQ-008 histogram_input_mem_raddr0 / histogram_input_mem_raddr1  in  16 each  histogram engine input read addresses.
REQ-009 histogram_computation_done, cdf_done, output_wt_done  in  1 each  phase completion from the histogram, cdf and divider engines.
REQ-010 start_histogram, start_cdf, start_divider  out  1 each  engine enables.
REQ-011 input_mem_read_finished  out  1  input frame fully read.
REQ-012 scratch_sel  out  2  scratch-memory owner: 0 histogram, 1 cdf, 2 divider, 3 none.
REQ-013 busy, frame_done, error  out  1 each  status.
REQ-014 phase  out  3  current state encoding.
REQ-015 frame_count  out  16  completed frames.

Function
REQ-016 States SHALL be IDLE=0, HIST=1, GAP1=2, CDF=3, GAP2=4, DIV=5, DONE=6, ERR=7; phase SHALL equal the current state.
REQ-017 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-018 IDLE: go=1 -> HIST on the next edge; go=0 -> stay.
REQ-019 HIST: histogram_computation_done=1 -> GAP1.
REQ-020 GAP1: GAP_CYCLES cycles, then -> CDF.
REQ-021 CDF: cdf_done=1 -> GAP2.
REQ-022 GAP2: GAP_CYCLES cycles, then -> DIV.
REQ-023 DIV: output_wt_done=1 -> DONE.
REQ-024 DONE: lasts one cycle, then -> IDLE.
REQ-025 start_histogram SHALL be 1 exactly while in HIST; start_cdf exactly while in CDF; start_divider exactly while in DIV. These enables are level signals, not pulses.
REQ-026 scratch_sel SHALL be 0 in HIST, 1 in CDF, 2 in DIV and 3 in all other states.
REQ-027 busy SHALL be 1 in HIST through DONE inclusive and 0 in IDLE and ERR.
REQ-028 In HIST, input_mem_read_finished SHALL be set the cycle after either raddr input equals LAST_INPUT_ADDR.
REQ-029 Once set, input_mem_read_finished SHALL hold until the state leaves HIST, then clear.
REQ-030 A done input SHALL be ignored in any state other than its own phase; go SHALL be ignored outside IDLE.
REQ-031 frame_done SHALL be 1 for exactly the DONE cycle.
REQ-032 frame_count SHALL increment by 1 on entry to DONE and wrap from 16'hFFFF to 0.
REQ-033 Watchdog: a 20-bit counter SHALL clear on entry to HIST, CDF or DIV and increment each cycle in that state.
REQ-034 If the watchdog counter reaches TIMEOUT_CYCLES-1 with no done, the next state SHALL be ERR.
REQ-035 If done and timeout coincide, done SHALL win.
REQ-036 ERR: error=1, all starts 0, scratch_sel=3; ERR SHALL be left only via abort or reset, to IDLE.
REQ-037 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, drop all starts and error, and leave frame_count unchanged.
REQ-038 abort has priority over go, done and timeout.
REQ-039 Frame latency: go accepted at edge N -> start_histogram high from N+1; minimum total go-to-frame_done is 3 + 2*GAP_CYCLES + engine cycles.

Reset
REQ-040 reset=1 at a rising edge SHALL force IDLE from any state, including mid-phase.
REQ-041 Reset values SHALL be: all starts 0, input_mem_read_finished 0, scratch_sel 3, busy 0, frame_done 0, error 0, phase 0, frame_count 0, watchdog 0, gap counter 0.
REQ-042 reset SHALL have priority over abort.

Verification
REQ-043 Nominal frame: go pulse, done inputs each 5 cycles after their start -> phase 1,2,2,3,4,4,5,6,0; frame_done one cycle; frame_count=1.
REQ-044 Input-read flag: in HIST drive raddr1=4095 at cycle k -> input_mem_read_finished=1 from k+1 until leaving HIST; raddr=4094 -> stays 0.
REQ-045 Stray dones: cdf_done and output_wt_done held high during HIST -> no state change; start_cdf stays 0.
REQ-046 Timeout with TIMEOUT_CYCLES=8 in CDF -> ERR 8 cycles after CDF entry, error=1, go ignored; abort -> IDLE, error=0.
REQ-047 Reset mid-DIV and abort mid-HIST -> IDLE next edge, starts 0, scratch_sel=3; frame_count is 0 after reset and unchanged after abort.
REQ-048 Wrap: preload to 65535 completed frames (force or iterate) and complete one more -> frame_count=0.
